// File: rtl/msg_seq_pkg.sv
// Shared types and constants for the hash message padding sequencer.
// Used by msg_seq and msg_seq_padgen.
package msg_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, CLR, ARM, DATA, MARK, ALIGN, ZLEN, CMP, FIN
  } st_e;

  localparam logic [1:0]  OP_WR_D  = 2'b00;
  localparam int          BLK_256  = 64;
  localparam int          BLK_512  = 128;
  localparam int          LEN_256  = 8;
  localparam int          LEN_512  = 16;
  localparam logic [31:0] PAD_MARK = 32'h8000_0000;

  // Byte offset at which the length field starts.
  function automatic logic [6:0] len_pos(input logic m);
    return m ? 7'(BLK_512 - LEN_512) : 7'(BLK_256 - LEN_256);
  endfunction

endpackage

// File: rtl/msg_seq_padgen.sv
// Padding word generator for MARK/ALIGN/ZLEN (combinational).
// i_fill marks zero words that only run to the block end.
module msg_seq_padgen
  import msg_seq_pkg::*;
(
  input  st_e         i_st,
  input  logic [6:0]  i_ofs,
  input  logic [31:0] i_len,
  input  logic        i_mode,
  input  logic        i_fill,
  output logic [31:0] o_wr_d,
  output logic [1:0]  o_size,
  output logic        o_last
);

  logic [6:0] w_hi;
  logic [6:0] w_lo;
  logic       w_zl;

  assign w_hi = i_mode ? 7'(BLK_512 - 8) : 7'(BLK_256 - 8);
  assign w_lo = w_hi + 7'd4;
  assign w_zl = (i_st == ZLEN) && !i_fill;

  always_comb begin
    o_wr_d = '0;
    o_size = '0;
    o_last = 1'b0;
    unique case (1'b1)
      i_st == MARK: begin
        o_wr_d = PAD_MARK;
        o_size = 2'd1;
        o_last = 1'b1;
      end
      i_st == ALIGN: begin
        o_size = 2'd0 - i_ofs[1:0];
        o_last = 1'b1;
      end
      w_zl && (i_ofs == w_hi): begin
        o_wr_d = {29'd0, i_len[31:29]};
      end
      w_zl && (i_ofs == w_lo): begin
        o_wr_d = {i_len[28:0], 3'd0};
        o_last = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msg_seq.sv
// Message padding sequencer: streams data, 0x80 mark and length into the buffer.
// MSG_SEQ_ABORT_EN adds an abort input that drops the job back to IDLE.
module msg_seq
  import msg_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s1_flg_384,
  input  logic        start,
  input  logic [31:0] msg_len,
  input  logic [31:0] din,
  input  logic        din_vld,
  output logic        din_rdy,
  input  logic        m_buf_rdy,
  input  logic        rcv_nxt1,
  input  logic        msg_update,
  output logic        m_buf_en,
  output logic        m_buf_clr,
  output logic [1:0]  m_buf_op,
  output logic [31:0] wr_d,
  output logic        wr_en,
  output logic [1:0]  rcv_size,
  output logic        rcv_last,
  output logic        cmp_start,
  input  logic        cmp_done,
`ifdef MSG_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done
);

  st_e         r_st, w_nxt;
  st_e         r_seg, w_nseg;
  logic [6:0]  r_ofs;
  logic [31:0] r_len;
  logic [31:0] r_rem;
  logic        r_mode;
  logic        r_ended;
  logic        r_final;
  logic        r_fill;
  logic        r_kill;
  logic [1:0]  r_cph;

  logic [31:0] w_pd;
  logic [1:0]  w_psz;
  logic        w_plast;
  logic        w_abort;
  logic        w_dlast;
  logic [6:0]  w_mask;
  logic [6:0]  w_base;
  logic [2:0]  w_bytes;
  logic [7:0]  w_sum;
  logic [6:0]  w_ofs_n;
  logic        w_acc;
  logic        w_wrap;

`ifdef MSG_SEQ_ABORT_EN
  assign w_abort = abort && (r_st != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_dlast = r_rem <= 32'd4;
  assign w_mask  = r_mode ? 7'h7f : 7'h3f;
  assign w_base  = len_pos(r_mode);
  assign busy    = rst_n && (r_st != IDLE);

  msg_seq_padgen u_pad (
    .i_st   (r_st),
    .i_ofs  (r_ofs),
    .i_len  (r_len),
    .i_mode (r_mode),
    .i_fill (r_fill),
    .o_wr_d (w_pd),
    .o_size (w_psz),
    .o_last (w_plast)
  );

  always_comb begin
    w_nxt     = r_st;
    w_nseg    = r_seg;
    m_buf_en  = 1'b0;
    m_buf_clr = r_kill;
    m_buf_op  = OP_WR_D;
    wr_d      = '0;
    wr_en     = 1'b0;
    rcv_size  = '0;
    rcv_last  = 1'b0;
    din_rdy   = 1'b0;
    cmp_start = 1'b0;
    done      = 1'b0;
    if (!rst_n || w_abort) begin
      m_buf_clr = 1'b1;
      w_nxt     = IDLE;
    end else begin
      unique case (r_st)
        IDLE: if (start) w_nxt = CLR;
        CLR: begin
          m_buf_clr = 1'b1;
          w_nxt     = ARM;
        end
        ARM: begin
          m_buf_en = 1'b1;
          if (m_buf_rdy) w_nxt = r_seg;
        end
        DATA: begin
          din_rdy  = 1'b1;
          wr_d     = din;
          wr_en    = din_vld;
          rcv_last = w_dlast;
          rcv_size = w_dlast ? r_rem[1:0] : 2'd0;
        end
        MARK, ALIGN, ZLEN: begin
          wr_en    = 1'b1;
          wr_d     = w_pd;
          rcv_size = w_psz;
          rcv_last = w_plast;
        end
        CMP: begin
          cmp_start = (r_cph == 2'd1);
          if (r_cph == 2'd2 && cmp_done)
            w_nxt = r_final ? FIN : (r_ended ? ARM : r_seg);
        end
        FIN: begin
          done  = 1'b1;
          w_nxt = IDLE;
        end
        default: w_nxt = IDLE;
      endcase
    end
    // size 0 encodes a full word
    w_bytes = {rcv_size == 2'd0, rcv_size};
    w_sum   = {1'b0, r_ofs} + {5'd0, w_bytes};
    w_ofs_n = w_sum[6:0] & w_mask;
    w_acc   = wr_en && rcv_nxt1;
    w_wrap  = w_acc && (w_ofs_n == 7'd0);
    if (r_st == DATA)
      w_nseg = MARK;
    else if (r_st == MARK)
      w_nseg = (w_ofs_n[1:0] != 2'd0) ? ALIGN : ZLEN;
    else if (r_st == ALIGN)
      w_nseg = ZLEN;
    if (w_acc)
      w_nxt = w_wrap ? CMP : (rcv_last ? ARM : r_st);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st    <= IDLE;
      r_seg   <= DATA;
      r_ofs   <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_mode  <= 1'b0;
      r_ended <= 1'b0;
      r_final <= 1'b0;
      r_fill  <= 1'b0;
      r_kill  <= 1'b1;
      r_cph   <= 2'd0;
    end else begin
      r_st   <= w_nxt;
      r_kill <= w_abort;
      if (r_st == IDLE && start) begin
        r_len   <= msg_len;
        r_rem   <= msg_len;
        r_mode  <= s1_flg_384;
        r_ofs   <= '0;
        r_seg   <= (msg_len != 32'd0) ? DATA : MARK;
        r_ended <= 1'b0;
        r_final <= 1'b0;
        r_fill  <= 1'b0;
      end
      // past the length slot: zero-fill to the block end first
      if (r_st == ARM && m_buf_rdy && r_seg == ZLEN)
        r_fill <= r_ofs > w_base;
      if (w_acc) begin
        r_ofs   <= w_ofs_n;
        r_ended <= rcv_last;
        if (r_st == DATA) r_rem <= r_rem - {29'd0, w_bytes};
        if (rcv_last) r_seg <= w_nseg;
        if (w_wrap) r_fill <= 1'b0;
        if (r_st == ZLEN && rcv_last) r_final <= 1'b1;
      end
      if (r_st == CMP) begin
        unique case (r_cph)
          2'd0:    if (msg_update) r_cph <= 2'd1;
          2'd1:    r_cph <= 2'd2;
          default: if (cmp_done) r_cph <= 2'd0;
        endcase
      end else begin
        r_cph <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_msg_seq.sv
// Scoreboard bench for msg_seq: expected buffer writes queued per job,
// a negedge monitor pops and compares every accepted write.
module tb_msg_seq;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic        l;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s1_flg_384;
  logic        start;
  logic [31:0] msg_len;
  logic [31:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic        m_buf_rdy;
  logic        rcv_nxt1;
  logic        msg_update;
  logic        m_buf_en;
  logic        m_buf_clr;
  logic [1:0]  m_buf_op;
  logic [31:0] wr_d;
  logic        wr_en;
  logic [1:0]  rcv_size;
  logic        rcv_last;
  logic        cmp_start;
  logic        cmp_done;
  logic        busy;
  logic        done;
`ifdef MSG_SEQ_ABORT_EN
  logic        abort;
`endif

  wr_t         exp_q[$];
  logic [31:0] d_arr[64];
  int          d_n;
  int          d_idx;
  bit          d_on;
  bit          d_gap;
  int          cmp_dly;
  int          n_chk;
  int          n_bad;
  int          n_cs;
  int          n_done;
  int          n_viol;
  int          n_wr;
  bit          in_cmp;
  logic [31:0] first_wd;
  logic [31:0] last_wd;

  always #5 clk = ~clk;

  assign din_vld = d_on && !d_gap && (d_idx < d_n);
  assign din     = (d_idx < d_n) ? d_arr[d_idx[5:0]] : 32'd0;

  msg_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s1_flg_384 (s1_flg_384),
    .start      (start),
    .msg_len    (msg_len),
    .din        (din),
    .din_vld    (din_vld),
    .din_rdy    (din_rdy),
    .m_buf_rdy  (m_buf_rdy),
    .rcv_nxt1   (rcv_nxt1),
    .msg_update (msg_update),
    .m_buf_en   (m_buf_en),
    .m_buf_clr  (m_buf_clr),
    .m_buf_op   (m_buf_op),
    .wr_d       (wr_d),
    .wr_en      (wr_en),
    .rcv_size   (rcv_size),
    .rcv_last   (rcv_last),
    .cmp_start  (cmp_start),
    .cmp_done   (cmp_done),
`ifdef MSG_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Data source and buffer-ready pattern.
  initial begin
    bit x;
    d_gap = 1'b0;
    forever begin
      @(negedge clk);
      x = din_vld && din_rdy && rst_n;
      @(posedge clk);
      #1;
      if (x) d_idx++;
      d_gap     = ($urandom_range(3) == 0);
      m_buf_rdy = 1'($urandom_range(1));
    end
  end

  // Compression engine: cmp_done cmp_dly cycles after cmp_start.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_start) begin
        repeat (cmp_dly) @(negedge clk);
        @(posedge clk);
        #1 cmp_done = 1'b1;
        @(posedge clk);
        #1 cmp_done = 1'b0;
      end
    end
  end

  // Monitor.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_cmp = 1'b0;
      end else begin
        if (cmp_start) begin
          n_cs++;
          in_cmp = 1'b1;
        end
        if (in_cmp && (wr_en || din_rdy)) n_viol++;
        if (in_cmp && cmp_done) in_cmp = 1'b0;
        if (done) n_done++;
        if (wr_en && rcv_nxt1) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL wr_extra: got d=%0h s=%0d l=%0b want none",
                     wr_d, rcv_size, rcv_last);
          end else begin
            e = exp_q.pop_front();
            if (wr_d !== e.d || rcv_size !== e.s || rcv_last !== e.l) begin
              n_bad++;
              $display("FAIL wr%0d: got d=%0h s=%0d l=%0b want d=%0h s=%0d l=%0b",
                       n_wr, wr_d, rcv_size, rcv_last, e.d, e.s, e.l);
            end
          end
          if (n_wr == 0) first_wd = wr_d;
          last_wd = wr_d;
          n_wr++;
        end
      end
    end
  end

  // Reference: padded length T rounded to whole blocks, chunked as the
  // buffer sees it (data words, mark byte, align, zero words, length).
  task automatic build(input bit mode, input int len);
    int blk, lw, nw, pos, tot, rem;
    logic [31:0] l32;
    logic [7:0] b;
    blk = mode ? 128 : 64;
    lw  = mode ? 16 : 8;
    nw  = (len + 3) / 4;
    l32 = 32'(len);
    for (int w = 0; w < 64; w++) begin
      d_arr[w] = '0;
      for (int k = 0; k < 4; k++) begin
        b = 8'(8'h61 + 4 * w + k);
        if (4 * w + k < len) d_arr[w][31-8*k -: 8] = b;
      end
    end
    d_n = nw;
    exp_q.delete();
    for (int w = 0; w < nw; w++) begin
      rem = len - 4 * w;
      exp_q.push_back('{d_arr[w], (w == nw - 1) ? 2'(rem % 4) : 2'd0,
                        w == nw - 1});
    end
    exp_q.push_back('{32'h8000_0000, 2'd1, 1'b1});
    pos = len + 1;
    if (pos % 4 != 0) begin
      exp_q.push_back('{32'd0, 2'(4 - pos % 4), 1'b1});
      pos = pos + 4 - pos % 4;
    end
    tot = ((len + 1 + lw + blk - 1) / blk) * blk;
    for (int p = pos; p < tot - lw; p += 4)
      exp_q.push_back('{32'd0, 2'd0, 1'b0});
    for (int k = 0; k < lw / 4 - 2; k++)
      exp_q.push_back('{32'd0, 2'd0, 1'b0});
    exp_q.push_back('{{29'd0, l32[31:29]}, 2'd0, 1'b0});
    exp_q.push_back('{{l32[28:0], 3'd0}, 2'd0, 1'b1});
  endtask

  task automatic begin_job(input bit mode, input int len, input int dly);
    build(mode, len);
    cmp_dly = dly;
    n_cs = 0; n_done = 0; n_viol = 0; n_wr = 0;
    d_idx = 0; d_on = 1'b1;
    @(posedge clk);
    #1;
    s1_flg_384 = mode;
    msg_len    = 32'(len);
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_job(input string nm, input bit mode, input int len,
                         input int blocks, input logic [31:0] fw,
                         input logic [31:0] lw, input int dly,
                         input bit restart);
    int t;
    begin_job(mode, len, dly);
    if (restart) begin
      repeat (4) @(posedge clk);
      #1;
      msg_len = 32'd7; s1_flg_384 = ~mode; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    t = 0;
    while (n_done == 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    d_on = 1'b0;
    chk({nm, "_done"},   32'(n_done), 32'd1);
    chk({nm, "_blocks"}, 32'(n_cs), 32'(blocks));
    chk({nm, "_first"},  first_wd, fw);
    chk({nm, "_lenlo"},  last_wd, lw);
    chk({nm, "_left"},   32'(exp_q.size()), 32'd0);
    chk({nm, "_cmpq"},   32'(n_viol), 32'd0);
    @(negedge clk);
    chk({nm, "_idle"},   {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int t;
    n_chk = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; msg_len = '0; s1_flg_384 = 1'b0;
    d_on = 1'b0; d_idx = 0; d_n = 0;
    rcv_nxt1 = 1'b1; msg_update = 1'b1; m_buf_rdy = 1'b1;
    cmp_done = 1'b0; cmp_dly = 2;
`ifdef MSG_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    chk("rst_clr",  {31'd0, m_buf_clr}, 32'd1);
    chk("rst_outs", {25'd0, busy, done, wr_en, din_rdy, cmp_start,
                     m_buf_en, rcv_last}, 32'd0);
    chk("rst_wr",   {wr_d[29:0], m_buf_op}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_clr",  {31'd0, m_buf_clr}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_job("l3",   1'b0, 3,   1, 32'h6162_6300, 32'h18,  3,  1'b0);
    run_job("l56",  1'b0, 56,  2, 32'h6162_6364, 32'h1c0, 20, 1'b1);
    run_job("l0",   1'b0, 0,   1, 32'h8000_0000, 32'h0,   1,  1'b0);
    run_job("l112", 1'b1, 112, 2, 32'h6162_6364, 32'h380, 4,  1'b0);
    run_job("l63",  1'b0, 63,  2, 32'h6162_6364, 32'h1f8, 0,  1'b0);
    run_job("l64",  1'b0, 64,  2, 32'h6162_6364, 32'h200, 5,  1'b0);
    run_job("l5m1", 1'b1, 5,   1, 32'h6162_6364, 32'h28,  2,  1'b0);

    // Reset in the middle of DATA.
    begin_job(1'b0, 56, 2);
    t = 0;
    while (d_idx < 5 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("rstm_reach", {31'd0, d_idx >= 5}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstm_clr0", {31'd0, m_buf_clr}, 32'd1);
    chk("rstm_out0", {29'd0, wr_en, din_rdy, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    d_on = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rstm_clr1", {31'd0, m_buf_clr}, 32'd1);
    chk("rstm_idle", {31'd0, busy}, 32'd0);
    n_done = 0;
    @(posedge clk);
    #1 cmp_done = 1'b1;
    @(posedge clk);
    #1 cmp_done = 1'b0;
    repeat (20) @(posedge clk);
    chk("rstm_nodone", 32'(n_done), 32'd0);
    chk("rstm_busy",   {31'd0, busy}, 32'd0);

`ifdef MSG_SEQ_ABORT_EN
    begin_job(1'b0, 56, 2);
    t = 0;
    while (d_idx < 4 && t < 500) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abt_clr0", {31'd0, m_buf_clr}, 32'd1);
    chk("abt_out0", {28'd0, wr_en, din_rdy, m_buf_en, cmp_start}, 32'd0);
    @(posedge clk);
    #1 abort = 1'b0;
    d_on = 1'b0;
    exp_q.delete();
    n_done = 0;
    @(negedge clk);
    chk("abt_idle", {31'd0, busy}, 32'd0);
    chk("abt_clr1", {31'd0, m_buf_clr}, 32'd1);
    repeat (20) @(posedge clk);
    chk("abt_nodone", 32'(n_done), 32'd0);
`endif

    run_job("again", 1'b0, 3, 1, 32'h6162_6300, 32'h18, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/msg_seq.md
MSG_SEQ -- requirements
Module: msg_seq

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-003 s1_flg_384  in  1  mode: 0 = 64-byte block with 8-byte length field; 1 = 128-byte block with 16-byte length field.
REQ-004 start  in  1  single-cycle job request; sampled only in IDLE.
REQ-005 msg_len  in  32  message length in bytes; captured on start.
REQ-006 din / din_vld / din_rdy  in 32 / in 1 / out 1  message word stream, big-endian bytes; transfer when din_vld & din_rdy.
REQ-007 m_buf_rdy, rcv_nxt1, msg_update  in  1 each  status from the message buffer.
REQ-008 m_buf_en, m_buf_clr  out  1 each; m_buf_op  out  2  buffer command (00 = WR_D only).
REQ-009 wr_d  out 32; wr_en  out 1; rcv_size  out 2; rcv_last  out 1  buffer write port.
REQ-010 cmp_start  out 1  one-cycle compression request; cmp_done  in 1  compression complete.
REQ-011 busy  out 1  high outside IDLE; done  out 1  one-cycle job-complete pulse.

Function
REQ-012 States SHALL be IDLE, CLR, ARM, DATA, MARK, ALIGN, ZLEN, CMP, FIN.
REQ-013 IDLE+start: capture msg_len, clear byte offset ofs, goto CLR; CLR pulses m_buf_clr for 1 cycle, then ARM.
REQ-014 ARM SHALL hold m_buf_en=1, m_buf_op=00 until m_buf_rdy, then enter the pending segment: DATA if bytes remaining > 0, otherwise MARK.
REQ-015 DATA: wr_d=din, wr_en=din_vld, din_rdy=1; on the last word (remaining <= 4) rcv_last=1 and rcv_size=remaining mod 4.
REQ-016 MARK: single write wr_d=32'h8000_0000, rcv_last=1, rcv_size=1.
REQ-017 ALIGN: entered only when ofs mod 4 != 0; single zero write, rcv_last=1, rcv_size=4-(ofs mod 4).
REQ-018 ZLEN: full zero words while ofs != blk-L (L=8/16), then length words: all zero except the final two, {29'b0,msg_len[31:29]} and {msg_len[28:0],3'b0}; rcv_last=1 with rcv_size=0 on the final word only.
REQ-019 Each segment ending in rcv_last SHALL pass through ARM before the next segment.
REQ-020 Every accepted write (rcv_nxt1=1) SHALL advance ofs by its byte count, modulo blk (64/128).
REQ-021 A write that wraps ofs to 0 SHALL suspend the current segment: goto CMP, wr_en=0, din_rdy=0.
REQ-022 CMP: wait for msg_update, pulse cmp_start the next cycle, wait for cmp_done, then resume the suspended segment; if that segment had just ended, go to ARM instead.
REQ-023 Completion of the final length write SHALL lead through CMP to FIN; FIN pulses done, then IDLE.
REQ-024 start outside IDLE SHALL be ignored; msg_len=0 SHALL skip DATA.
REQ-025 The length field SHALL always fit within the final block; a second block is produced when needed (offset after MARK > blk-L).

Reset
REQ-026 With rst_n low at a clock edge: state=IDLE, ofs=0; all outputs 0 except m_buf_clr=1 for that cycle.
REQ-027 Reset mid-job SHALL abandon the job with no done pulse; a cmp_done arriving later SHALL be ignored.

Configuration
REQ-028 MSG_SEQ_ABORT_EN defined: adds input abort (1 bit); abort in any non-IDLE state pulses m_buf_clr, drops every request output, and returns to IDLE in 1 cycle with no done pulse. Undefined: no abort port exists and jobs always run to FIN.

Structure
REQ-029 The shared package msg_seq_pkg SHALL hold the state enum, OP_WR_D, BLK_256=64, BLK_512=128, LEN_256=8, LEN_512=16 and PAD_MARK.
REQ-030 The sub-module msg_seq_padgen SHALL produce wr_d/rcv_size/rcv_last for MARK/ALIGN/ZLEN from ofs, msg_len and mode, with no state of its own.

Verification
REQ-031 Mode 0, len=3, din=32'h6162_6300: DATA size 3, MARK, zero fill to ofs 56, length words 0, 0x18; one cmp_start, then done.
REQ-032 Mode 0, len=56: block 1 holds data plus 0x80 and zero fill; block 2 holds zeros plus length 0x1C0; exactly 2 cmp_start pulses.
REQ-033 Mode 0, len=0: first write is 0x8000_0000 and the last length word is 0; one block.
REQ-034 Mode 1, len=112: 2 blocks; 4 length words, the last = 0x380.
REQ-035 cmp_done delayed 20 cycles: wr_en and din_rdy stay 0 throughout CMP, and no write is lost or duplicated.
REQ-036 Mid-DATA rst_n low (and abort when MSG_SEQ_ABORT_EN is defined): next cycle IDLE, m_buf_clr=1, no done pulse.
